mac_scheduler: RTL and testbench



---
 rtl/mac_scheduler.sv | 136 +++++++++++++
 tb/tb_mac_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_scheduler.sv
// Purpose : sequences operand chunks into a pipelined SIMD MAC and accumulates
//           cfg_num_chunks results per output, cfg_num_outputs outputs per job.
// Latency : last chunk issued at t -> out_valid at t+MAC_LATENCY+1; done one
//           cycle after the final output handshake.
// Backpressure: in_ready only in ISSUE; out_data held stable while out_ready is low.
//
// Ports:
//   clk, arst_n_in                    clock, async active-low reset
//   start, cfg_num_chunks/outputs     job start and per-job configuration
//   busy, done                        job status, done is a one-cycle pulse
//   in_valid/in_ready, mac_valid      chunk handshake and MAC input_valid
//   mac_out                           MAC result (valid MAC_LATENCY after issue)
//   out_valid/out_ready, out_data     accumulated result handshake
module mac_scheduler #(
    parameter int MAC_WIDTH   = 38,
    parameter int ACC_WIDTH   = 48,
    parameter int MAC_LATENCY = 6,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                        clk,
    input  logic                        arst_n_in,
    input  logic                        start,
    input  logic [CNT_WIDTH-1:0]        cfg_num_chunks,
    input  logic [CNT_WIDTH-1:0]        cfg_num_outputs,
    output logic                        busy,
    output logic                        done,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        mac_valid,
    input  logic signed [MAC_WIDTH-1:0] mac_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] out_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    // Token position that lines up with a valid mac_out.
    localparam logic [MAC_LATENCY-1:0] EXIT_MASK = MAC_LATENCY'(1) << (MAC_LATENCY - 1);

    logic [1:0]                  state;
    logic [CNT_WIDTH-1:0]        num_chunks;
    logic [CNT_WIDTH-1:0]        num_outputs;
    logic [CNT_WIDTH-1:0]        chunk_cnt;
    logic [CNT_WIDTH-1:0]        out_cnt;
    logic [MAC_LATENCY-1:0]      tok_sr;
    logic signed [ACC_WIDTH-1:0] acc;

    logic                        tok_exit;
    logic                        last_exit;
    logic [ACC_WIDTH-1:0]        mac_ext;
    logic signed [ACC_WIDTH-1:0] acc_sum;
    logic [CNT_WIDTH-1:0]        chunk_nxt;
    logic [CNT_WIDTH-1:0]        out_nxt;

    assign busy      = (state != S_IDLE);
    assign in_ready  = (state == S_ISSUE);
    assign mac_valid = in_valid & in_ready;
    assign out_valid = (state == S_HOLD);

    assign tok_exit  = tok_sr[MAC_LATENCY-1];
    // Last token leaving: nothing else is still behind it in the pipe.
    assign last_exit = tok_exit && ((tok_sr & ~EXIT_MASK) == '0);
    assign mac_ext   = {{(ACC_WIDTH-MAC_WIDTH){mac_out[MAC_WIDTH-1]}}, mac_out};
    assign acc_sum   = acc + $signed(mac_ext);
    assign chunk_nxt = chunk_cnt + CNT_WIDTH'(1);
    assign out_nxt   = out_cnt + CNT_WIDTH'(1);

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state       <= S_IDLE;
            num_chunks  <= '0;
            num_outputs <= '0;
            chunk_cnt   <= '0;
            out_cnt     <= '0;
            tok_sr      <= '0;
            acc         <= '0;
            out_data    <= '0;
            done        <= 1'b0;
        end else begin
            done   <= 1'b0;
            // The MAC pipeline never stalls, so the tokens shift every cycle.
            tok_sr <= (tok_sr << 1) | MAC_LATENCY'(mac_valid);
            if (tok_exit) begin
                acc <= acc_sum;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_chunks  <= (cfg_num_chunks == '0) ? CNT_WIDTH'(1) : cfg_num_chunks;
                        num_outputs <= (cfg_num_outputs == '0) ? CNT_WIDTH'(1) : cfg_num_outputs;
                        chunk_cnt   <= '0;
                        out_cnt     <= '0;
                        acc         <= '0;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mac_valid) begin
                        chunk_cnt <= chunk_nxt;
                        if (chunk_nxt == num_chunks) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Fold the final MAC result straight into the output so
                    // out_valid rises one cycle after the last token exits.
                    if (last_exit) begin
                        out_data <= acc_sum;
                        acc      <= '0;
                        state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_cnt <= out_nxt;
                        if (out_nxt == num_outputs) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            chunk_cnt <= '0;
                            state     <= S_ISSUE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_scheduler.sv
// Purpose : directed self-checking bench for mac_scheduler with a small MAC
//           pipeline model (MAC_LATENCY=6) returning the value driven at issue.
// Inputs driven at posedge+1, outputs sampled at posedge+2.
module tb_mac_scheduler;

    logic               clk = 1'b0;
    logic               arst_n_in;
    logic               start;
    logic [7:0]         cfg_num_chunks;
    logic [7:0]         cfg_num_outputs;
    logic               busy;
    logic               done;
    logic               in_valid;
    logic               in_ready;
    logic               mac_valid;
    logic signed [37:0] mac_out;
    logic               out_valid;
    logic               out_ready;
    logic signed [47:0] out_data;

    int n_checks = 0;
    int n_errors = 0;
    int n;

    always #5 clk = ~clk;

    mac_scheduler #(
        .MAC_WIDTH   (38),
        .ACC_WIDTH   (48),
        .MAC_LATENCY (6),
        .CNT_WIDTH   (8)
    ) dut (
        .clk             (clk),
        .arst_n_in       (arst_n_in),
        .start           (start),
        .cfg_num_chunks  (cfg_num_chunks),
        .cfg_num_outputs (cfg_num_outputs),
        .busy            (busy),
        .done            (done),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .mac_valid       (mac_valid),
        .mac_out         (mac_out),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data)
    );

    // MAC model: the value on chunk_val at issue appears on mac_out six
    // cycles later; random garbage otherwise. Reset by the same reset.
    logic signed [37:0] chunk_val;
    logic signed [37:0] garbage;
    logic [5:0]         pv;
    logic signed [37:0] pd [6];

    always @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            pv      <= '0;
            garbage <= '0;
            for (int i = 0; i < 6; i++) pd[i] <= '0;
        end else begin
            pv      <= {pv[4:0], mac_valid};
            pd[0]   <= chunk_val;
            for (int i = 1; i < 6; i++) pd[i] <= pd[i-1];
            garbage <= 38'({$urandom, $urandom});
        end
    end

    assign mac_out = pv[5] ? pd[5] : garbage;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called at sample time with cnt cycles already elapsed since the last
    // issue; returns the elapsed count at which out_valid is seen.
    task automatic wait_ov(input int cnt, output int res);
        res = cnt;
        while (!out_valid && res < 100) begin
            next_cycle();
            #1;
            res++;
        end
    endtask

    task automatic handshake_done(input string tag);
        out_ready = 1'b1;
        next_cycle();
        out_ready = 1'b0;
        #1;
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    logic signed [37:0] v2 [4];
    logic signed [37:0] v3 [3];
    logic signed [37:0] v4 [6];
    logic signed [47:0] e4 [3];
    logic [5:0]         pat3;
    int                 pulses, bad, k, issued, nres, done_c;
    logic               prev_hs;
    logic signed [47:0] d0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        arst_n_in = 1'b0; start = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        cfg_num_chunks = 8'd1; cfg_num_outputs = 8'd1; chunk_val = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_mac_valid", mac_valid, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 48'sd0);
        arst_n_in = 1'b1; start = 1'b0; in_valid = 1'b0;
        next_cycle();

        // Single chunk, 1234 comes back at t+6, out_valid at t+7.
        start = 1'b1; cfg_num_chunks = 8'd1; cfg_num_outputs = 8'd1;
        next_cycle();
        start = 1'b0; in_valid = 1'b1; chunk_val = 38'sd1234;
        #1;
        chk("t1_busy", busy, 1'b1);
        chk("t1_in_ready", in_ready, 1'b1);
        chk("t1_mac_valid", mac_valid, 1'b1);
        next_cycle();
        in_valid = 1'b0;
        #1;
        chk("t1_drain_rdy", in_ready, 1'b0);
        wait_ov(1, n);
        chk("t1_ov_latency", n, 7);
        chk("t1_data", out_data, 48'sd1234);
        handshake_done("t1");
        next_cycle();
        #1;
        chk("t1_done_pulse", done, 1'b0);

        // Accumulation with sign: 100 - 300 + (2^37-1) + 5 = 2^37 - 196.
        v2[0] = 38'sd100; v2[1] = -38'sd300; v2[2] = 38'sh1F_FFFF_FFFF; v2[3] = 38'sd5;
        start = 1'b1; cfg_num_chunks = 8'd4;
        next_cycle();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; chunk_val = v2[i];
            next_cycle();
        end
        in_valid = 1'b0;
        #1;
        wait_ov(1, n);
        chk("t2_ov_latency", n, 7);
        chk("t2_data", out_data, 48'sh1F_FFFF_FF3C);
        handshake_done("t2");

        // Bubbles on in_valid (1,0,0,1,0,1) and 11 cycles of out_ready low.
        v3[0] = 38'sd7; v3[1] = 38'sd11; v3[2] = -38'sd20;
        pat3 = 6'b101001;
        pulses = 0; bad = 0; k = 0;
        start = 1'b1; cfg_num_chunks = 8'd3;
        next_cycle();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid  = pat3[i];
            chunk_val = (pat3[i] && k < 3) ? v3[k] : 38'sd999;
            #1;
            if (mac_valid) begin
                pulses++;
                k++;
            end
            next_cycle();
        end
        in_valid = 1'b1;
        n = 1;
        #1;
        while (!out_valid && n < 100) begin
            if (in_ready) bad++;
            if (mac_valid) pulses++;
            next_cycle();
            #1;
            n++;
        end
        chk("t3_ov_latency", n, 7);
        chk("t3_data", out_data, -48'sd2);
        d0 = out_data;
        for (int j = 0; j < 10; j++) begin
            next_cycle();
            #1;
            if (out_data !== d0 || !out_valid || in_ready || mac_valid) bad++;
            if (mac_valid) pulses++;
        end
        in_valid = 1'b0;
        handshake_done("t3");
        chk("t3_pulses", pulses, 3);
        chk("t3_hold_stable", bad, 0);

        // Three outputs of two chunks, out_ready tied high: done at start+28.
        v4[0] = 38'sd10;  v4[1] = 38'sd20;
        v4[2] = -38'sd5;  v4[3] = -38'sd6;
        v4[4] = 38'sd1000; v4[5] = 38'sd1;
        e4[0] = 48'sd30; e4[1] = -48'sd11; e4[2] = 48'sd1001;
        issued = 0; nres = 0; done_c = -1; prev_hs = 1'b0;
        start = 1'b1; cfg_num_chunks = 8'd2; cfg_num_outputs = 8'd3;
        out_ready = 1'b1; in_valid = 1'b1; chunk_val = v4[0];
        next_cycle();
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            chunk_val = v4[(issued < 6) ? issued : 0];
            #1;
            if (prev_hs && nres < 3) chk("t4_rdy_after_hs", in_ready, 1'b1);
            prev_hs = 1'b0;
            if (mac_valid) issued++;
            if (out_valid) begin
                if (nres < 3) chk("t4_data", out_data, e4[nres]);
                nres++;
                prev_hs = 1'b1;
            end
            if (done && done_c < 0) done_c = c;
            next_cycle();
        end
        out_ready = 1'b0; in_valid = 1'b0;
        chk("t4_done_cycle", done_c, 28);
        chk("t4_results", nres, 3);
        chk("t4_issued", issued, 6);

        // Zero config behaves as 1/1; start during ISSUE is ignored.
        start = 1'b1; cfg_num_chunks = 8'd0; cfg_num_outputs = 8'd0;
        next_cycle();
        cfg_num_chunks = 8'd5; cfg_num_outputs = 8'd5;
        #1;
        chk("t5_in_ready", in_ready, 1'b1);
        next_cycle();
        start = 1'b0; in_valid = 1'b1; chunk_val = 38'sd55;
        #1;
        chk("t5_mac_valid", mac_valid, 1'b1);
        next_cycle();
        in_valid = 1'b0;
        #1;
        chk("t5_one_chunk", in_ready, 1'b0);
        wait_ov(1, n);
        chk("t5_ov_latency", n, 7);
        chk("t5_data", out_data, 48'sd55);
        handshake_done("t5");

        // Reset with three tokens in flight, then a clean job.
        start = 1'b1; cfg_num_chunks = 8'd4; cfg_num_outputs = 8'd1;
        next_cycle();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; chunk_val = 38'(i + 1);
            next_cycle();
        end
        in_valid = 1'b0;
        repeat (3) next_cycle();
        in_valid = 1'b1;
        #1;
        chk("t6_busy_pre", busy, 1'b1);
        arst_n_in = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_in_ready", in_ready, 1'b0);
        chk("t6_rst_mac_valid", mac_valid, 1'b0);
        chk("t6_rst_out_valid", out_valid, 1'b0);
        chk("t6_rst_out_data", out_data, 48'sd0);
        chk("t6_rst_done", done, 1'b0);
        repeat (2) next_cycle();
        arst_n_in = 1'b1; in_valid = 1'b0;
        next_cycle();
        start = 1'b1; cfg_num_chunks = 8'd1; cfg_num_outputs = 8'd1;
        next_cycle();
        start = 1'b0; in_valid = 1'b1; chunk_val = 38'sd77;
        next_cycle();
        in_valid = 1'b0;
        #1;
        wait_ov(1, n);
        chk("t6_ov_latency", n, 7);
        chk("t6_data", out_data, 48'sd77);
        handshake_done("t6");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
